// File: rtl/mem_stage.sv
// MEM stage: holds the EX bundle, waits for the load response, extracts/extends load data, hands off to WB.
// ALU ops leave after 1 cycle and loads on data_ok; a response that arrives while WB stalls is buffered until transfer.
module mem_stage #(
   parameter int EX_BUS_LEN  = 74,
   parameter int MEM_BUS_LEN = 103,
   parameter int BYPASS_LEN  = 39
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   EX_valid,
   input  logic                   EX_ready_go,
   input  logic [EX_BUS_LEN-1:0]  EXreg_bus,
   input  logic                   data_sram_data_ok,
   input  logic [31:0]            data_sram_rdata,
   input  logic                   WB_allow_in,
   output logic                   MEM_allow_in,
   output logic                   MEM_ready_go,
   output logic                   MEM_valid,
   output logic [MEM_BUS_LEN-1:0] MEMreg_bus,
   output logic [BYPASS_LEN-1:0]  MEM_bypass_bus
);

   typedef struct packed {
      logic [31:0] alu_result;
      logic [2:0]  ld_op;
      logic        rf_we;
      logic        res_from_mem;
      logic [4:0]  rf_waddr;
      logic [31:0] pc;
   } ex_bus_t;

   // Width is the sum of the listed fields: 32+32+1+1+5+32.
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] mem_result;
      logic        rf_we;
      logic        res_from_mem;
      logic [4:0]  rf_waddr;
      logic [31:0] pc;
   } mem_bus_t;

   typedef struct packed {
      logic [4:0]  rf_waddr;
      logic        rf_we;
      logic        pending;
      logic [31:0] rf_wdata;
   } bypass_t;

   logic        valid_q, valid_d;
   ex_bus_t     bundle_q, bundle_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_data_q, buf_data_d;

   logic        ex_fire;
   logic        leave;
   logic        data_accept;
   logic [31:0] raw;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;
   logic [31:0] mem_result;
   mem_bus_t    mem_bus;
   bypass_t     bypass;

   always_comb begin
      MEM_ready_go = ~bundle_q.res_from_mem | buf_valid_q | data_sram_data_ok;
      MEM_allow_in = ~valid_q | (MEM_ready_go & WB_allow_in);
      MEM_valid    = valid_q & MEM_ready_go;
      ex_fire      = EX_valid & EX_ready_go;
      leave        = MEM_ready_go & WB_allow_in;
      data_accept  = valid_q & bundle_q.res_from_mem & ~buf_valid_q & data_sram_data_ok;

      valid_d     = valid_q;
      bundle_d    = bundle_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      if (MEM_allow_in) begin
         valid_d = ex_fire;
         if (ex_fire) begin
            bundle_d = ex_bus_t'(EXreg_bus);
         end
      end
      // Leaving wins over filling: the word is consumed in the same cycle it arrives.
      if (leave) begin
         buf_valid_d = 1'b0;
      end else if (data_accept & ~WB_allow_in) begin
         buf_valid_d = 1'b1;
         buf_data_d  = data_sram_rdata;
      end
   end

   always_comb begin
      raw = buf_valid_q ? buf_data_q : data_sram_rdata;
      case (bundle_q.alu_result[1:0])
         2'd0:    ld_byte = raw[7:0];
         2'd1:    ld_byte = raw[15:8];
         2'd2:    ld_byte = raw[23:16];
         default: ld_byte = raw[31:24];
      endcase
      ld_half = bundle_q.alu_result[1] ? raw[31:16] : raw[15:0];

      case (bundle_q.ld_op)
         3'b001:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b101:  load_val = {24'd0, ld_byte};
         3'b010:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b110:  load_val = {16'd0, ld_half};
         default: load_val = raw;
      endcase
      mem_result = bundle_q.res_from_mem ? load_val : 32'd0;

      mem_bus.alu_result   = bundle_q.alu_result;
      mem_bus.mem_result   = mem_result;
      mem_bus.rf_we        = bundle_q.rf_we & valid_q;
      mem_bus.res_from_mem = bundle_q.res_from_mem;
      mem_bus.rf_waddr     = bundle_q.rf_waddr;
      mem_bus.pc           = bundle_q.pc;
      MEMreg_bus           = valid_q ? mem_bus : '0;

      bypass.rf_waddr = bundle_q.rf_waddr;
      bypass.rf_we    = bundle_q.rf_we & valid_q;
      bypass.pending  = valid_q & bundle_q.res_from_mem & ~MEM_ready_go;
      bypass.rf_wdata = bundle_q.res_from_mem ? mem_result : bundle_q.alu_result;
      MEM_bypass_bus  = bypass;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         bundle_q    <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= 32'd0;
      end else begin
         valid_q     <= valid_d;
         bundle_q    <= bundle_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed test-plan records followed by randomized traffic.
module tb_mem_stage;

   logic         clk = 1'b0;
   logic         reset;
   logic         EX_valid, EX_ready_go;
   logic [73:0]  EXreg_bus;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         WB_allow_in;
   logic         MEM_allow_in, MEM_ready_go, MEM_valid;
   logic [102:0] MEMreg_bus;
   logic [38:0]  MEM_bypass_bus;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .reset(reset),
      .EX_valid(EX_valid), .EX_ready_go(EX_ready_go), .EXreg_bus(EXreg_bus),
      .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
      .WB_allow_in(WB_allow_in),
      .MEM_allow_in(MEM_allow_in), .MEM_ready_go(MEM_ready_go), .MEM_valid(MEM_valid),
      .MEMreg_bus(MEMreg_bus), .MEM_bypass_bus(MEM_bypass_bus)
   );

   typedef struct {
      logic [31:0] alu;
      logic [2:0]  op;
      logic        we;
      logic        rfm;
      logic [4:0]  waddr;
      logic [31:0] word;
      int          delay;
      int          stall;
   } stim_t;

   int n_vec = 0;
   int n_err = 0;

   stim_t        stimq[$];
   logic [102:0] sbq[$];
   logic         mon_en = 1'b0;
   logic         occ = 1'b0, occ_load = 1'b0, got = 1'b0;

   task automatic check(input string name, input logic [102:0] act, input logic [102:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] w);
      int unsigned a, b, h;
      a = addr % 4;
      b = (w >> (8 * a)) % 256;
      h = (w >> (16 * (a / 2))) % 65536;
      case (op)
         3'b001:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'b101:  return b;
         3'b010:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'b110:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [38:0] exp_bypass(input logic [102:0] e);
      return {e[36:32], e[38], 1'b0, (e[37] ? e[70:39] : e[102:71])};
   endfunction

   function automatic stim_t mk(input logic [31:0] alu, input logic [2:0] op, input logic we, input logic rfm,
                                input logic [4:0] waddr, input logic [31:0] word, input int delay, input int stall);
      stim_t s;
      s.alu = alu; s.op = op; s.we = we; s.rfm = rfm; s.waddr = waddr;
      s.word = word; s.delay = delay; s.stall = stall;
      return s;
   endfunction

   // Monitor: per-cycle handshake expectations plus scoreboard pop on transfer.
   initial begin
      logic ready_e;
      logic [102:0] e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            ready_e = !occ_load || got || data_sram_data_ok;
            if (occ) begin
               check("mem_valid", MEM_valid, ready_e);
               check("pending", MEM_bypass_bus[32], occ_load && !ready_e);
               check("allow_in", MEM_allow_in, ready_e && WB_allow_in);
            end else begin
               check("idle_valid", MEM_valid, 1'b0);
               check("idle_allow_in", MEM_allow_in, 1'b1);
            end
            if (data_sram_data_ok) check("data_ok_legal", occ && occ_load && !got, 1'b1);
            if (MEM_valid) begin
               if (sbq.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_underflow: MEM_valid with no expected bundle at %0t", $time);
               end else begin
                  e = sbq[0];
                  check("memreg_bus", MEMreg_bus, e);
                  check("bypass_bus", MEM_bypass_bus, exp_bypass(e));
                  if (WB_allow_in) void'(sbq.pop_front());
               end
            end
         end
      end
   end

   // Driver: EX source, SRAM responder and WB sink.
   initial begin
      stim_t        cur;
      logic         have, cur_rand, s_fire, s_leave, s_dok;
      logic         resp_pending;
      int           resp_cnt, stall_cnt, popped, ndir, cycles;
      logic [31:0]  resp_word, pc_ctr, cur_pc;
      logic [2:0]   ops [8];
      ops = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110, 3'b011, 3'b100, 3'b111};

      stimq.push_back(mk(32'h0000_1234, 3'b000, 1'b1, 1'b0, 5'd5,  32'h0,         0, 0));
      stimq.push_back(mk(32'h1000_0000, 3'b000, 1'b1, 1'b1, 5'd6,  32'hDEADBEEF,  3, 0));
      stimq.push_back(mk(32'h1000_0003, 3'b001, 1'b1, 1'b1, 5'd7,  32'h80112233,  0, 0));
      stimq.push_back(mk(32'h1000_0003, 3'b101, 1'b1, 1'b1, 5'd8,  32'h80112233,  1, 0));
      stimq.push_back(mk(32'h1000_0002, 3'b010, 1'b1, 1'b1, 5'd9,  32'h80112233,  0, 0));
      stimq.push_back(mk(32'h1000_0000, 3'b110, 1'b1, 1'b1, 5'd10, 32'h0000A5A5,  2, 0));
      stimq.push_back(mk(32'h2000_0004, 3'b000, 1'b1, 1'b1, 5'd11, 32'hCAFEF00D,  1, 2));
      stimq.push_back(mk(32'h2000_0008, 3'b000, 1'b1, 1'b1, 5'd12, 32'h13579BDF,  2, 0));
      for (int i = 0; i < 6; i++)
         stimq.push_back(mk(32'hA000_0000 + i, 3'b000, 1'b1, 1'b0, 5'(13 + i), 32'h0, 0, 0));
      ndir = stimq.size();
      for (int i = 0; i < 400; i++)
         stimq.push_back(mk($urandom, ops[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
                            5'($urandom), $urandom, $urandom_range(0, 3), 0));

      reset = 1'b1; EX_valid = 1'b0; EX_ready_go = 1'b0; EXreg_bus = '0;
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; WB_allow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_mem_valid", MEM_valid, 1'b0);
      check("rst_memreg_bus", MEMreg_bus, 103'd0);
      check("rst_bypass", MEM_bypass_bus, 39'd0);
      check("rst_ready_go", MEM_ready_go, 1'b1);
      check("rst_allow_in", MEM_allow_in, 1'b1);
      mon_en = 1'b1;

      have = 1'b0; cur_rand = 1'b0; resp_pending = 1'b0; resp_cnt = 0; stall_cnt = 0;
      popped = 0; cycles = 0; pc_ctr = 32'h1C00_0000; cur_pc = 32'h0; resp_word = 32'h0;
      cur = mk(32'h0, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 0, 0);
      forever begin
         @(negedge clk);
         s_fire  = EX_valid && EX_ready_go && MEM_allow_in;
         s_dok   = data_sram_data_ok;
         s_leave = occ && (!occ_load || got || s_dok) && WB_allow_in;
         @(posedge clk);
         #1;
         if (occ && occ_load && s_dok && !s_leave) got = 1'b1;
         if (s_fire) begin
            occ = 1'b1; occ_load = cur.rfm; got = 1'b0;
            sbq.push_back({cur.alu, (cur.rfm ? ref_load(cur.op, cur.alu, cur.word) : 32'h0),
                           cur.we, cur.rfm, cur.waddr, cur_pc});
            if (cur.rfm) begin
               resp_pending = 1'b1; resp_cnt = cur.delay; resp_word = cur.word;
            end
            have = 1'b0;
         end else if (s_leave) begin
            occ = 1'b0;
         end

         data_sram_data_ok = 1'b0;
         data_sram_rdata   = cur_rand ? $urandom : 32'h0;
         if (resp_pending) begin
            if (resp_cnt == 0) begin
               data_sram_data_ok = 1'b1; data_sram_rdata = resp_word;
               resp_pending = 1'b0; stall_cnt = cur.stall;
            end else begin
               resp_cnt--;
            end
         end

         if (!have && stimq.size() > 0) begin
            cur = stimq.pop_front(); have = 1'b1; cur_rand = (popped >= ndir);
            popped++; cur_pc = pc_ctr; pc_ctr += 4;
         end
         if (cur_rand) begin
            WB_allow_in = ($urandom_range(0, 2) != 0);
         end else if (stall_cnt > 0) begin
            WB_allow_in = 1'b0; stall_cnt--;
         end else begin
            WB_allow_in = 1'b1;
         end
         EX_valid    = have && (!cur_rand || $urandom_range(0, 3) != 0);
         EX_ready_go = !cur_rand || $urandom_range(0, 3) != 0;
         EXreg_bus   = {cur.alu, cur.op, cur.we, cur.rfm, cur.waddr, cur_pc};

         cycles++;
         if (!have && stimq.size() == 0 && !occ && sbq.size() == 0) break;
         if (cycles > 20000) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d bundles still expected", sbq.size());
            break;
         end
      end

      // A load waits for data, reset hits, then a stale data_ok arrives.
      mon_en = 1'b0;
      WB_allow_in = 1'b1; EX_valid = 1'b1; EX_ready_go = 1'b1; data_sram_data_ok = 1'b0;
      EXreg_bus = {32'h3000_0000, 3'b000, 1'b1, 1'b1, 5'd3, 32'h1C00_FFF0};
      @(posedge clk);
      #1 EX_valid = 1'b0;
      @(negedge clk);
      check("load_wait_pending", MEM_bypass_bus[32], 1'b1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
      @(negedge clk);
      check("late_dok_valid", MEM_valid, 1'b0);
      check("late_dok_bus", MEMreg_bus, 103'd0);
      check("late_dok_bypass_we", MEM_bypass_bus[33], 1'b0);
      check("late_dok_allow_in", MEM_allow_in, 1'b1);
      @(posedge clk);
      #1 data_sram_data_ok = 1'b0;
      @(negedge clk);
      check("post_rst_valid", MEM_valid, 1'b0);
      check("post_rst_bus", MEMreg_bus, 103'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
